// File: rtl/seg_scan_driver_pkg.sv
// seg_scan_driver_pkg: shared segment table and scan_word field layout for the display peripheral
package seg_scan_driver_pkg;

    localparam int ANODE_MSB = 11;
    localparam int ANODE_LSB = 8;
    localparam int DP_BIT    = 7;

    localparam logic [31:0] SCAN_IDLE = 32'h0000_0FFF;

    // Active-low g..a patterns, element n is hex digit n
    localparam logic [15:0][6:0] SEG_AL = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/seg_scan_driver_decode.sv
// hex_seg_decode: nibble to active-low seven-segment pattern
module hex_seg_decode
    import seg_scan_driver_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg_n
);

    assign seg_n = SEG_AL[nib];

endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed four-digit hex display scanner with frame-synchronous update
module seg_scan_driver
    import seg_scan_driver_pkg::*;
#(
    parameter int CLK_DIV = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [15:0] wr_data,
    input  logic [3:0]  dp_mask,
    input  logic        blank_lz,
    output logic [31:0] scan_word,
    output logic        digit_tick
);

    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   shadow_q, shadow_d, disp_q, disp_d;
    logic [31:0]   scan_word_q, scan_word_d, word;
    logic          digit_tick_q, digit_tick_d;
    logic          tc, blank;
    logic [3:0]    nib;
    logic [6:0]    seg_n;
    logic [7:0]    lo;

    assign nib = disp_q[{idx_q, 2'b00} +: 4];

    hex_seg_decode u_dec (.nib(nib), .seg_n(seg_n));

    // Next-state: prescaler, digit index, shadow/display buffering and the registered scan word
    always_comb begin
        tc           = cnt_q == CW'(CLK_DIV - 1);
        cnt_d        = tc ? '0 : cnt_q + CW'(1);
        idx_d        = tc ? idx_q + 2'd1 : idx_q;
        shadow_d     = wr_en ? wr_data : shadow_q;
        disp_d       = (tc && idx_q == 2'd3) ? shadow_d : disp_q;
        blank        = blank_lz && idx_q != 2'd0 && (disp_q >> {idx_q, 2'b00}) == '0;
        lo           = blank ? 8'hFF : {~dp_mask[idx_q], seg_n};
        word         = '0;
        word[ANODE_MSB:ANODE_LSB] = ~(4'b0001 << idx_q);
        word[DP_BIT:0] = lo;
        scan_word_d  = tc ? word : scan_word_q;
        digit_tick_d = tc;
    end

    // State registers with asynchronous reset to a dark display at digit 0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            shadow_q     <= '0;
            disp_q       <= '0;
            scan_word_q  <= SCAN_IDLE;
            digit_tick_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            disp_q       <= disp_d;
            scan_word_q  <= scan_word_d;
            digit_tick_q <= digit_tick_d;
        end
    end

    assign scan_word  = scan_word_q;
    assign digit_tick = digit_tick_q;

endmodule
